// File: rtl/multi_interval_timer.sv
// Multi-channel Avalon-MM interval timer: NUM_CH prescaled down-counters with
// one-shot/continuous modes, snapshot capture and a shared interrupt line.
module multi_interval_timer #(
  parameter  int NUM_CH       = 2,
  parameter  int CNT_W        = 32,
  parameter  int PRESC_W      = 8,
  parameter  int RESET_PERIOD = 49999,
  localparam int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int AW           = 3 + CH_W
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [AW-1:0] address,
  input  logic          chipselect,
  input  logic          write_n,
  input  logic [15:0]   writedata,
  output logic [15:0]   readdata,
  output logic          irq
);

  typedef enum logic [2:0] {
    REG_STATUS  = 3'd0,
    REG_CONTROL = 3'd1,
    REG_PERIODL = 3'd2,
    REG_PERIODH = 3'd3,
    REG_SNAPL   = 3'd4,
    REG_SNAPH   = 3'd5,
    REG_PRESC   = 3'd6,
    REG_IRQVEC  = 3'd7
  } reg_e;

  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;

  typedef struct packed {
    logic [CNT_W-1:0]   counter;
    logic [CNT_W-1:0]   period;
    logic [CNT_W-1:0]   snap;
    logic [PRESC_W-1:0] presc;
    logic [PRESC_W-1:0] pc;
    logic [3:0]         ctrl;
    logic               run;
    logic               to;
  } chan_t;

  chan_t             ch_q [NUM_CH];
  chan_t             ch_d [NUM_CH];
  logic [15:0]       readdata_q;
  logic [15:0]       readdata_d;

  logic              wr_en;
  reg_e              reg_sel;
  logic [CH_W-1:0]   ch_sel;
  logic [NUM_CH-1:0] wr_ch;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] irq_vec;

  // Replace one 16-bit half of a CNT_W value; bits above CNT_W fall away.
  function automatic logic [CNT_W-1:0] merge_half(input logic [CNT_W-1:0] cur,
                                                  input logic hi,
                                                  input logic [15:0] wd);
    logic [31:0] t;
    t = 32'(cur);
    if (hi) t[31:16] = wd;
    else    t[15:0]  = wd;
    return t[CNT_W-1:0];
  endfunction

  function automatic logic [15:0] half16(input logic [CNT_W-1:0] v, input logic hi);
    logic [31:0] t;
    t = 32'(v);
    return hi ? t[31:16] : t[15:0];
  endfunction

  assign wr_en   = chipselect & ~write_n;
  assign reg_sel = reg_e'(address[2:0]);
  assign ch_sel  = address[AW-1:3];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign wr_ch[g]   = wr_en && (ch_sel == CH_W'(g));
    assign tick[g]    = ch_q[g].run && (ch_q[g].pc == ch_q[g].presc);
    assign irq_vec[g] = ch_q[g].to & ch_q[g].ctrl[CTRL_ITO];
  end

  assign irq      = |irq_vec;
  assign readdata = readdata_q;

  // Order matters: STATUS clear precedes the tick so a coincident timeout
  // survives, and bus writes come last so period/START override the tick.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      // NOTE: every field gets a default before any branch, so no latch is inferred.
      ch_d[i] = ch_q[i];

      if (wr_ch[i] && reg_sel == REG_STATUS) ch_d[i].to = 1'b0;

      if (!ch_q[i].run || tick[i]) ch_d[i].pc = '0;
      else                         ch_d[i].pc = ch_q[i].pc + PRESC_W'(1);

      if (tick[i]) begin
        if (ch_q[i].counter != '0) begin
          ch_d[i].counter = ch_q[i].counter - CNT_W'(1);
        end else begin
          ch_d[i].counter = ch_q[i].period;
          ch_d[i].to      = 1'b1;
          if (!ch_q[i].ctrl[CTRL_CONT]) ch_d[i].run = 1'b0;
        end
      end

      if (wr_ch[i]) begin
        case (reg_sel)
          REG_CONTROL: begin
            ch_d[i].ctrl = writedata[3:0];
            if (writedata[CTRL_STOP]) ch_d[i].run = 1'b0;
            if (writedata[CTRL_START]) begin
              ch_d[i].run = 1'b1;
              ch_d[i].pc  = '0;
            end
          end
          REG_PERIODL, REG_PERIODH: begin
            ch_d[i].period  = merge_half(ch_q[i].period, reg_sel == REG_PERIODH, writedata);
            ch_d[i].counter = ch_d[i].period;
            ch_d[i].run     = 1'b0;
            ch_d[i].pc      = '0;
          end
          REG_SNAPL, REG_SNAPH: ch_d[i].snap = ch_q[i].counter;
          REG_PRESC: begin
            ch_d[i].presc = writedata[PRESC_W-1:0];
            ch_d[i].pc    = '0;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    chan_t sel;
    logic  sel_valid;
    sel        = '0;
    sel_valid  = 1'b0;
    readdata_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_sel == CH_W'(i)) begin
        sel       = ch_q[i];
        sel_valid = 1'b1;
      end
    end
    if (sel_valid) begin
      case (reg_sel)
        REG_STATUS:  readdata_d = {14'd0, sel.run, sel.to};
        REG_CONTROL: readdata_d = {12'd0, sel.ctrl};
        REG_PERIODL: readdata_d = half16(sel.period, 1'b0);
        REG_PERIODH: readdata_d = half16(sel.period, 1'b1);
        REG_SNAPL:   readdata_d = half16(sel.snap, 1'b0);
        REG_SNAPH:   readdata_d = half16(sel.snap, 1'b1);
        REG_PRESC:   readdata_d = 16'(sel.presc);
        REG_IRQVEC:  readdata_d = 16'(irq_vec);
        default:     readdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        // NOTE: sequential state uses non-blocking assignment so all registers update together.
        ch_q[i] <= '{counter: CNT_W'(RESET_PERIOD), period: CNT_W'(RESET_PERIOD),
                     snap: '0, presc: '0, pc: '0, ctrl: '0, run: 1'b0, to: 1'b0};
      end
      readdata_q <= '0;
    end else begin
      ch_q       <= ch_d;
      readdata_q <= readdata_d;
    end
  end

endmodule

// File: tb/tb_multi_interval_timer.sv
// Self-checking bench for multi_interval_timer: directed scenarios plus
// randomized period/prescaler runs checked against an arithmetic timing model.
module tb_multi_interval_timer;

  localparam int NUM_CH = 3;
  localparam int CNT_W = 32;
  localparam int PRESC_W = 8;
  localparam int RESET_PERIOD = 49999;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [AW-1:0] address;
  logic          chipselect;
  logic          write_n;
  logic [15:0]   writedata;
  logic [15:0]   readdata;
  logic          irq;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  multi_interval_timer #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRESC_W(PRESC_W), .RESET_PERIOD(RESET_PERIOD)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata), .irq(irq)
  );

  // Counter value after n edges following a START from a freshly loaded count p.
  function automatic int exp_count(input int p, input int r, input int n, input bit cont);
    int k;
    k = n / (r + 1);
    if (!cont && k > p) return p;
    return p - (k % (p + 1));
  endfunction

  task automatic bus_write(input int ch, input int r, input logic [15:0] d);
    address = AW'((ch << 3) | r); chipselect = 1'b1; write_n = 1'b0; writedata = d;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input int ch, input int r, output logic [15:0] d);
    address = AW'((ch << 3) | r); chipselect = 1'b1; write_n = 1'b1;
    @(posedge clk); #1;
    d = readdata; chipselect = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Edges from e0 until irq is first seen high; -1 if the bound expires.
  task automatic wait_irq(input int e0, input int limit, output int n);
    n = -1;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk); #1;
      if (irq) begin n = cyc - e0; break; end
    end
  endtask

  task automatic test_reset();
    logic [15:0] d;
    reset_n = 1'b0;
    @(posedge clk); #1;
    total++; if (readdata !== 16'h0) begin bad++; $display("FAIL reset_readdata: got %h want 0000", readdata); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b want 0", irq); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    bus_read(0, 2, d); total++; if (d !== 16'hC34F) begin bad++; $display("FAIL reset_periodl: got %h want c34f", d); end
    bus_read(0, 3, d); total++; if (d !== 16'h0) begin bad++; $display("FAIL reset_periodh: got %h want 0000", d); end
    bus_read(0, 0, d); total++; if (d !== 16'h0) begin bad++; $display("FAIL reset_status: got %h want 0000", d); end
    bus_read(0, 6, d); total++; if (d !== 16'h0) begin bad++; $display("FAIL reset_presc: got %h want 0000", d); end
    bus_read(1, 4, d); total++; if (d !== 16'h0) begin bad++; $display("FAIL reset_snapl: got %h want 0000", d); end
    bus_read(1, 1, d); total++; if (d !== 16'h0) begin bad++; $display("FAIL reset_control: got %h want 0000", d); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq_idle: got %b want 0", irq); end
  endtask

  task automatic test_registers();
    logic [15:0] d;
    bus_write(2, 3, 16'h1234);
    bus_read(2, 3, d); total++; if (d !== 16'h1234) begin bad++; $display("FAIL periodh_rw: got %h want 1234", d); end
    bus_read(2, 2, d); total++; if (d !== 16'hC34F) begin bad++; $display("FAIL periodl_kept: got %h want c34f", d); end
    bus_write(2, 6, 16'hFF5A);
    bus_read(2, 6, d); total++; if (d !== 16'h005A) begin bad++; $display("FAIL presc_width: got %h want 005a", d); end
    bus_write(2, 6, 16'h0000);
    bus_write(3, 2, 16'h0055);
    bus_read(3, 2, d); total++; if (d !== 16'h0) begin bad++; $display("FAIL bad_channel_read: got %h want 0000", d); end
    bus_read(0, 2, d); total++; if (d !== 16'hC34F) begin bad++; $display("FAIL bad_channel_alias: got %h want c34f", d); end
  endtask

  task automatic test_continuous();
    logic [15:0] d;
    int e0, n;
    bus_write(0, 2, 16'd4); bus_write(0, 3, 16'd0); bus_write(0, 6, 16'd0); bus_write(0, 0, 16'd0);
    bus_write(0, 1, 16'h7); e0 = cyc;
    wait_irq(e0, 50, n); total++; if (n !== 5) begin bad++; $display("FAIL cont_first_to: got %0d want 5", n); end
    bus_read(0, 0, d); total++; if (d !== 16'h3) begin bad++; $display("FAIL cont_status: got %h want 0003", d); end
    bus_write(0, 0, 16'h0);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL cont_irq_clear: got %b want 0", irq); end
    wait_irq(e0, 50, n); total++; if (n !== 10) begin bad++; $display("FAIL cont_second_to: got %0d want 10", n); end
    bus_read(1, 7, d); total++; if (d !== 16'h0001) begin bad++; $display("FAIL cont_irqvec: got %h want 0001", d); end
    bus_write(0, 1, 16'h8); bus_write(0, 0, 16'h0);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL cont_stop_irq: got %b want 0", irq); end
  endtask

  task automatic test_oneshot();
    logic [15:0] d;
    int e0, n;
    bus_write(1, 3, 16'd0); bus_write(1, 2, 16'd2); bus_write(1, 6, 16'd3); bus_write(1, 0, 16'd0);
    bus_write(1, 1, 16'h5); e0 = cyc;
    wait_irq(e0, 100, n); total++; if (n !== 12) begin bad++; $display("FAIL oneshot_to: got %0d want 12", n); end
    idle(20);
    bus_read(1, 0, d); total++; if (d !== 16'h1) begin bad++; $display("FAIL oneshot_status: got %h want 0001", d); end
    bus_write(1, 4, 16'h0);
    bus_read(1, 4, d); total++; if (d !== 16'd2) begin bad++; $display("FAIL oneshot_reload: got %h want 0002", d); end
    bus_read(1, 5, d); total++; if (d !== 16'd0) begin bad++; $display("FAIL oneshot_snaph: got %h want 0000", d); end
    bus_write(1, 0, 16'h0);
    idle(30);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL oneshot_single: got %b want 0", irq); end
    bus_write(1, 1, 16'h0);
  endtask

  task automatic test_snapshot();
    logic [15:0] d;
    int e0, n, k, want;
    bus_write(0, 3, 16'd0); bus_write(0, 2, 16'd9); bus_write(0, 6, 16'd0);
    bus_write(0, 1, 16'h6); e0 = cyc;
    k = $urandom_range(2, 25);
    idle(k - 1);
    bus_write(0, 5, 16'h0); n = cyc - e0;
    want = exp_count(9, 0, n - 1, 1'b1);
    bus_read(0, 4, d); total++; if (d !== 16'(want)) begin bad++; $display("FAIL snap_mid_count: got %0d want %0d", d, want); end
    bus_read(0, 5, d); total++; if (d !== 16'h0) begin bad++; $display("FAIL snap_high: got %h want 0000", d); end
    bus_write(0, 1, 16'h8);
  endtask

  task automatic test_status_race();
    logic [15:0] d;
    int e0;
    bus_write(0, 0, 16'h0); bus_write(0, 2, 16'd3);
    bus_write(0, 1, 16'h7); e0 = cyc;
    idle(3);
    bus_write(0, 0, 16'h0);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL race_irq: got %b want 1", irq); end
    bus_read(0, 0, d); total++; if (d !== 16'h3) begin bad++; $display("FAIL race_status: got %h want 0003", d); end
    bus_read(2, 7, d); total++; if (d !== 16'h0001) begin bad++; $display("FAIL race_irqvec: got %h want 0001", d); end
    bus_write(0, 1, 16'h8);
    bus_read(0, 0, d); total++; if ((d & 16'h2) !== 16'h0) begin bad++; $display("FAIL stop_run: got %h want run=0", d); end
    bus_write(0, 1, 16'hC);
    bus_read(0, 0, d); total++; if ((d & 16'h2) !== 16'h2) begin bad++; $display("FAIL start_wins: got %h want run=1", d); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL ito_clear_irq: got %b want 0", irq); end
  endtask

  task automatic test_period_while_running();
    logic [15:0] d;
    int e0, n;
    bus_write(0, 2, 16'd7);
    bus_read(0, 0, d); total++; if ((d & 16'h2) !== 16'h0) begin bad++; $display("FAIL period_stops_run: got %h want run=0", d); end
    bus_write(0, 4, 16'h0);
    bus_read(0, 4, d); total++; if (d !== 16'd7) begin bad++; $display("FAIL period_loads_counter: got %0d want 7", d); end
    bus_write(0, 0, 16'h0);
    bus_write(0, 1, 16'h5); e0 = cyc;
    wait_irq(e0, 50, n); total++; if (n !== 8) begin bad++; $display("FAIL restart_new_period: got %0d want 8", n); end
    bus_write(0, 1, 16'h8); bus_write(0, 0, 16'h0);
  endtask

  task automatic test_random();
    logic [15:0] d;
    int e0, n, k, ch, p, r, want;
    bit cont;
    for (int it = 0; it < 8; it++) begin
      ch = it % NUM_CH;
      p = $urandom_range(2, 12);
      r = $urandom_range(0, 3);
      cont = 1'($urandom_range(0, 1));
      bus_write(ch, 1, 16'h8); bus_write(ch, 3, 16'h0); bus_write(ch, 2, 16'(p));
      bus_write(ch, 6, 16'(r)); bus_write(ch, 0, 16'h0);
      bus_write(ch, 1, cont ? 16'h7 : 16'h5); e0 = cyc;
      wait_irq(e0, 300, n);
      total++; if (n !== (p + 1) * (r + 1)) begin bad++; $display("FAIL rand_to_time ch%0d p=%0d r=%0d: got %0d want %0d", ch, p, r, n, (p + 1) * (r + 1)); end
      bus_read((ch + 1) % NUM_CH, 7, d);
      total++; if (d !== 16'(1 << ch)) begin bad++; $display("FAIL rand_irqvec ch%0d: got %h want %h", ch, d, 16'(1 << ch)); end
      k = $urandom_range(0, 40);
      idle(k);
      bus_write(ch, 4, 16'h0); n = cyc - e0;
      want = exp_count(p, r, n - 1, cont);
      bus_read(ch, 4, d);
      total++; if (d !== 16'(want)) begin bad++; $display("FAIL rand_snap ch%0d p=%0d r=%0d cont=%0d: got %0d want %0d", ch, p, r, cont, d, want); end
      bus_read(ch, 0, d);
      total++; if (d !== (cont ? 16'h3 : 16'h1)) begin bad++; $display("FAIL rand_status ch%0d: got %h want %h", ch, d, cont ? 16'h3 : 16'h1); end
      bus_write(ch, 1, 16'h8); bus_write(ch, 0, 16'h0);
    end
  endtask

  task automatic test_reset_midcount();
    logic [15:0] d;
    bus_write(1, 3, 16'd0); bus_write(1, 2, 16'd100); bus_write(1, 1, 16'h7);
    idle(5);
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    total++; if (readdata !== 16'h0) begin bad++; $display("FAIL midreset_readdata: got %h want 0000", readdata); end
    bus_read(1, 2, d); total++; if (d !== 16'hC34F) begin bad++; $display("FAIL midreset_periodl: got %h want c34f", d); end
    bus_read(1, 1, d); total++; if (d !== 16'h0) begin bad++; $display("FAIL midreset_control: got %h want 0000", d); end
    bus_read(1, 0, d); total++; if (d !== 16'h0) begin bad++; $display("FAIL midreset_status: got %h want 0000", d); end
    bus_read(1, 6, d); total++; if (d !== 16'h0) begin bad++; $display("FAIL midreset_presc: got %h want 0000", d); end
    bus_write(1, 4, 16'h0);
    bus_read(1, 4, d); total++; if (d !== 16'hC34F) begin bad++; $display("FAIL midreset_counter: got %h want c34f", d); end
    idle(10);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL midreset_irq: got %b want 0", irq); end
  endtask

  initial begin
    reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = '0; writedata = '0;
    #1;
    test_reset();
    test_registers();
    test_continuous();
    test_oneshot();
    test_snapshot();
    test_status_race();
    test_period_while_running();
    test_random();
    test_reset_midcount();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
